bilinear_sample_feeder: RTL and testbench
=========================================

Name: bilinear_sample_feeder

Overview:
- Initiator/feeder for the downsampling layer's combinational bilinear interpolator.
- Walks an out_w x out_h output grid and computes each sample's 8.8 fixed-point source coordinate by accumulating step_x/step_y.
- Fetches the four neighbouring input pixels from a 1-cycle-latency feature-map RAM.
- Presents x, y, a1..a4 to the interpolator under a valid/ready handshake.

Parameters:
- DATA_W, 8, pixel width.
- COORD_W, 16, coordinate width in 8.8 fixed point.
- ADDR_W, 16, feature-map RAM address width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; latches the config and begins a frame. Ignored while busy=1.
- in_w, in_h  input  8 each  input map size in pixels, 1..255.
- out_w, out_h  input  8 each  output grid size.
- step_x, step_y  input  16 each  8.8 source step per output pixel (software precomputes in/out).
- mem_rd_en  output  1  RAM read strobe.
- mem_addr  output  ADDR_W  row-major address, y_int*in_w + x_int, base 0.
- mem_rdata  input  DATA_W  RAM data, valid the cycle after mem_rd_en.
- x, y  output  COORD_W  8.8 sample coordinate; the fraction is bits [7:0].
- a1, a2, a3, a4  output  DATA_W each  neighbour pixels, defined under Behaviour.
- out_valid  output  1  sample valid.
- out_ready  input  1  downstream accepts the sample.
- busy  output  1  high from the start acceptance cycle until done.
- done  output  1  one-cycle pulse after the last sample is accepted.

Behaviour:
- Reset: every output is 0 (x, y, a1..a4, mem_addr, mem_rd_en, out_valid, busy, done). FSM returns to IDLE. Accumulators clear.
- Reset asserted mid-frame aborts immediately. No done pulse; the partial frame is discarded.
- FSM states:
  - IDLE: on start, latch the config, clear x_acc/y_acc/col/row, set busy, go to FETCH. If out_w, out_h, in_w or in_h is 0, pulse done the next cycle, emit no samples, return to IDLE.
  - FETCH: 5 cycles, counter f = 0..4.
    - f = 0..3: mem_rd_en=1 with the addresses of neighbours 1..4 in order.
    - f = 1..4: capture mem_rdata into a1..a4 respectively.
    - mem_rd_en=0 at f=4. Then go to OUT.
  - OUT: out_valid=1; x, y, a1..a4 held stable while out_ready=0. No RAM reads while in OUT.
    - When out_valid && out_ready: if this is the last sample (col=out_w-1 and row=out_h-1), go to IDLE, pulse done, clear busy. Otherwise advance and go to FETCH.
    - out_valid deasserts the cycle after acceptance.
- Coordinate generation:
  - x_acc and y_acc are 24-bit and never wrap.
  - Column advance: x_acc += step_x, col++.
  - At col=out_w-1 the next advance sets x_acc=0, col=0, y_acc += step_y, row++.
- Clamping:
  - x_int = x_acc[15:8] if x_acc[23:8] <= in_w-1. Otherwise x_int = in_w-1 and the fraction is forced to 0.
  - y is clamped the same way against in_h-1.
  - The x/y outputs carry the clamped value.
- Neighbours:
  - x1 = min(x_int+1, in_w-1); y1 = min(y_int+1, in_h-1).
  - a1 = P(x_int, y_int), a2 = P(x1, y_int), a3 = P(x_int, y1), a4 = P(x1, y1).
  - Consequently a1 has weight (1-dx)(1-dy) downstream.
- Address arithmetic: y*in_w is an unsigned 8x8 product, zero-extended to ADDR_W.
- Throughput: at best 6 cycles per sample (5 FETCH + 1 OUT). The first out_valid appears 6 cycles after the start cycle.
- start or config changes while busy=1 have no effect.

Test Plan:
- Integer step: 4x4 map with P(c,r)=16r+c, out 2x2, step 0x0200.
  - Samples in order: (x,y)=(0x0000,0x0000) a=0,1,16,17; (0x0200,0x0000) a=2,3,18,19; (0x0000,0x0200) a=32,33,48,49; (0x0200,0x0200) a=34,35,50,51.
  - done pulses once, 1 cycle after the 4th acceptance.
- Fractional step: same map, out 3x3, step 0x0155.
  - Row 0: x=0x0155 gives x_int=1, a=1,2,17,18; x=0x02AA gives a=2,3,18,19.
  - Row 1: y=0x0155.
- Edge clamp: out 3x3, step 0x0180.
  - 3rd sample: x=0x0300, a1=a2=P(3,0)=3, a3=a4=19.
  - Last sample: a1..a4 all 51.
- Backpressure: hold out_ready=0 for 5 cycles on sample 2.
  - out_valid stays 1; x, y, a* are stable; mem_rd_en stays 0.
  - Resumes correctly once out_ready returns to 1.
- Degenerate config and start while busy: start with out_w=0 gives done 1 cycle later with no out_valid. A second start pulse mid-frame is ignored and the sample count is unchanged.
- Reset mid-frame: assert rst during FETCH of sample 3.
  - Next cycle all outputs are 0 and busy=0.
  - A new start runs a full frame correctly from sample 0.

Source files
------------

// File: rtl/bilinear_sample_feeder.sv
// Walks an output grid in 8.8 source coordinates, fetches the four neighbouring
// pixels from a 1-cycle-latency RAM and offers them to the bilinear interpolator.
module bilinear_sample_feeder #(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         in_w,
    input  logic [7:0]         in_h,
    input  logic [7:0]         out_w,
    input  logic [7:0]         out_h,
    input  logic [15:0]        step_x,
    input  logic [15:0]        step_y,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [DATA_W-1:0]  a1,
    output logic [DATA_W-1:0]  a2,
    output logic [DATA_W-1:0]  a3,
    output logic [DATA_W-1:0]  a4,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, OUT = 2'd2} state_t;

    state_t      state_r, state_s;
    logic [2:0]  f_r, f_s;
    logic [7:0]  col_r, col_s, row_r, row_s;
    logic [23:0] x_acc_r, x_acc_s, y_acc_r, y_acc_s;
    logic [7:0]  in_w_r, in_w_s, in_h_r, in_h_s, out_w_r, out_w_s, out_h_r, out_h_s;
    logic [15:0] step_x_r, step_x_s, step_y_r, step_y_s;
    logic        busy_s, done_s, rd_en_s;
    logic [7:0]  lim_x_s, lim_y_s, x1_s, y1_s;
    logic [15:0] xc_s, yc_s, addr_s;

    // Out-of-range coordinates snap to the last pixel with a zero fraction.
    function automatic logic [15:0] clamp_coord(input logic [23:0] acc, input logic [7:0] lim);
        logic [15:0] res;
        if (acc[23:8] <= {8'd0, lim}) begin
            res = acc[15:0];
        end else begin
            res = {lim, 8'd0};
        end
        return res;
    endfunction

    function automatic logic [7:0] next_idx(input logic [7:0] i, input logic [7:0] lim);
        return (i == lim) ? i : i + 8'd1;
    endfunction

    function automatic logic [15:0] pix_addr(input logic [7:0] px, input logic [7:0] py,
                                             input logic [7:0] w);
        return ({8'd0, py} * {8'd0, w}) + {8'd0, px};
    endfunction

    // Next-state logic for the frame walk, fetch counter and latched configuration.
    always_comb begin
        state_s  = state_r;
        f_s      = f_r;
        col_s    = col_r;
        row_s    = row_r;
        x_acc_s  = x_acc_r;
        y_acc_s  = y_acc_r;
        in_w_s   = in_w_r;
        in_h_s   = in_h_r;
        out_w_s  = out_w_r;
        out_h_s  = out_h_r;
        step_x_s = step_x_r;
        step_y_s = step_y_r;
        busy_s   = busy;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    in_w_s   = in_w;
                    in_h_s   = in_h;
                    out_w_s  = out_w;
                    out_h_s  = out_h;
                    step_x_s = step_x;
                    step_y_s = step_y;
                    x_acc_s  = 24'd0;
                    y_acc_s  = 24'd0;
                    col_s    = 8'd0;
                    row_s    = 8'd0;
                    f_s      = 3'd0;
                    if ((in_w == 8'd0) || (in_h == 8'd0) || (out_w == 8'd0) || (out_h == 8'd0)) begin
                        done_s = 1'b1;
                        busy_s = 1'b0;
                    end else begin
                        state_s = FETCH;
                        busy_s  = 1'b1;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            FETCH: begin
                if (f_r == 3'd4) begin
                    f_s     = 3'd0;
                    state_s = OUT;
                end else begin
                    f_s = f_r + 3'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (col_r == out_w_r - 8'd1) begin
                        if (row_r == out_h_r - 8'd1) begin
                            state_s = IDLE;
                            done_s  = 1'b1;
                            busy_s  = 1'b0;
                        end else begin
                            col_s   = 8'd0;
                            x_acc_s = 24'd0;
                            row_s   = row_r + 8'd1;
                            y_acc_s = y_acc_r + {8'd0, step_y_r};
                            state_s = FETCH;
                        end
                    end else begin
                        col_s   = col_r + 8'd1;
                        x_acc_s = x_acc_r + {8'd0, step_x_r};
                        state_s = FETCH;
                    end
                end else begin
                    state_s = OUT;
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Clamped coordinates and the read address that the next cycle will present.
    always_comb begin
        lim_x_s = in_w_s - 8'd1;
        lim_y_s = in_h_s - 8'd1;
        xc_s    = clamp_coord(x_acc_s, lim_x_s);
        yc_s    = clamp_coord(y_acc_s, lim_y_s);
        x1_s    = next_idx(xc_s[15:8], lim_x_s);
        y1_s    = next_idx(yc_s[15:8], lim_y_s);
        rd_en_s = (state_s == FETCH) && (f_s <= 3'd3);
        case (f_s[1:0])
            2'd0:    addr_s = pix_addr(xc_s[15:8], yc_s[15:8], in_w_s);
            2'd1:    addr_s = pix_addr(x1_s, yc_s[15:8], in_w_s);
            2'd2:    addr_s = pix_addr(xc_s[15:8], y1_s, in_w_s);
            default: addr_s = pix_addr(x1_s, y1_s, in_w_s);
        endcase
    end

    // State, configuration and registered outputs; RAM data lands in a1..a4 at f=1..4.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            f_r       <= 3'd0;
            col_r     <= 8'd0;
            row_r     <= 8'd0;
            x_acc_r   <= 24'd0;
            y_acc_r   <= 24'd0;
            in_w_r    <= 8'd0;
            in_h_r    <= 8'd0;
            out_w_r   <= 8'd0;
            out_h_r   <= 8'd0;
            step_x_r  <= 16'd0;
            step_y_r  <= 16'd0;
            mem_rd_en <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            x         <= {COORD_W{1'b0}};
            y         <= {COORD_W{1'b0}};
            a1        <= {DATA_W{1'b0}};
            a2        <= {DATA_W{1'b0}};
            a3        <= {DATA_W{1'b0}};
            a4        <= {DATA_W{1'b0}};
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_s;
            f_r       <= f_s;
            col_r     <= col_s;
            row_r     <= row_s;
            x_acc_r   <= x_acc_s;
            y_acc_r   <= y_acc_s;
            in_w_r    <= in_w_s;
            in_h_r    <= in_h_s;
            out_w_r   <= out_w_s;
            out_h_r   <= out_h_s;
            step_x_r  <= step_x_s;
            step_y_r  <= step_y_s;
            mem_rd_en <= rd_en_s;
            mem_addr  <= rd_en_s ? ADDR_W'(addr_s) : {ADDR_W{1'b0}};
            x         <= COORD_W'(xc_s);
            y         <= COORD_W'(yc_s);
            out_valid <= (state_s == OUT);
            busy      <= busy_s;
            done      <= done_s;
            if (state_r == FETCH) begin
                case (f_r)
                    3'd1:    a1 <= mem_rdata;
                    3'd2:    a2 <= mem_rdata;
                    3'd3:    a3 <= mem_rdata;
                    3'd4:    a4 <= mem_rdata;
                    default: a1 <= a1;
                endcase
            end else begin
                a1 <= a1;
            end
        end
    end

endmodule

// File: tb/tb_bilinear_sample_feeder.sv
// Directed bench: a sample-list model built from the source-coordinate formulas
// is compared against the DUT on every valid cycle; literals pin the model.
module tb_bilinear_sample_feeder;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [7:0]  in_w, in_h, out_w, out_h;
    logic [15:0] step_x, step_y;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'd0;
    logic [15:0] x, y;
    logic [7:0]  a1, a2, a3, a4;
    logic        out_valid, busy, done;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  a1;
        logic [7:0]  a2;
        logic [7:0]  a3;
        logic [7:0]  a4;
    } samp_t;

    samp_t      q[$];
    logic [7:0] mem [0:255];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_acc = 0;
    bit         cmp_en = 1'b0;
    bit         done_chk_en = 1'b0;
    bit         done_due = 1'b0;

    bilinear_sample_feeder dut (
        .clk(clk), .rst(rst), .start(start),
        .in_w(in_w), .in_h(in_h), .out_w(out_w), .out_h(out_h),
        .step_x(step_x), .step_y(step_y),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .x(x), .y(y), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_samp(input string nm, input samp_t s, input int ex, input int ey,
                            input int e1, input int e2, input int e3, input int e4);
        chk({nm, ".x"}, s.x, ex);
        chk({nm, ".y"}, s.y, ey);
        chk({nm, ".a1"}, s.a1, e1);
        chk({nm, ".a2"}, s.a2, e2);
        chk({nm, ".a3"}, s.a3, e3);
        chk({nm, ".a4"}, s.a4, e4);
    endtask

    function automatic logic [7:0] pix(input int c, input int r);
        return 8'(16 * r + c);
    endfunction

    // Expected sample list: coordinate = index * step, then clamp and pick neighbours.
    task automatic build_model(input int iw, input int ih, input int ow, input int oh,
                               input int sx, input int sy);
        q.delete();
        n_acc = 0;
        for (int r = 0; r < oh; r++) begin
            for (int c = 0; c < ow; c++) begin
                samp_t s;
                int xa, ya, xi, yi, xf, yf, xn, yn;
                xa = c * sx;
                ya = r * sy;
                if ((xa / 256) > iw - 1) begin xi = iw - 1; xf = 0; end
                else begin xi = xa / 256; xf = xa % 256; end
                if ((ya / 256) > ih - 1) begin yi = ih - 1; yf = 0; end
                else begin yi = ya / 256; yf = ya % 256; end
                xn = (xi + 1 > iw - 1) ? iw - 1 : xi + 1;
                yn = (yi + 1 > ih - 1) ? ih - 1 : yi + 1;
                s.x  = 16'(xi * 256 + xf);
                s.y  = 16'(yi * 256 + yf);
                s.a1 = pix(xi, yi);
                s.a2 = pix(xn, yi);
                s.a3 = pix(xi, yn);
                s.a4 = pix(xn, yn);
                q.push_back(s);
            end
        end
    endtask

    // Per-cycle comparison against the head of the model list.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (done_chk_en) chk("done_pulse", done, done_due);
            done_due = 1'b0;
            if (out_valid === 1'b1) begin
                chk("rd_en_in_out", mem_rd_en, 1'b0);
                if (q.size() == 0) begin
                    chk("unexpected_valid", out_valid, 1'b0);
                end else begin
                    chk("x", x, q[0].x);
                    chk("y", y, q[0].y);
                    chk("a1", a1, q[0].a1);
                    chk("a2", a2, q[0].a2);
                    chk("a3", a3, q[0].a3);
                    chk("a4", a4, q[0].a4);
                    if (out_ready === 1'b1) begin
                        void'(q.pop_front());
                        n_acc++;
                        if (q.size() == 0) done_due = 1'b1;
                    end
                end
            end
        end
    end

    task automatic start_frame(input int ow, input int oh, input int sx, input int sy);
        @(posedge clk); #1;
        in_w = 8'd4; in_h = 8'd4;
        out_w = 8'(ow); out_h = 8'(oh);
        step_x = 16'(sx); step_y = 16'(sy);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_frame(input int exp_n);
        int k = 0;
        while (done !== 1'b1 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("frame_timeout", (k < 500), 1'b1);
        chk("sample_count", n_acc, exp_n);
        chk("model_drained", q.size(), 0);
        chk("busy_at_done", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (n_acc < n && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        chk("acc_timeout", (k < 500), 1'b1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".x"}, x, 16'h0000);
        chk({nm, ".y"}, y, 16'h0000);
        chk({nm, ".a"}, {a1, a2, a3, a4}, 32'h0);
        chk({nm, ".addr"}, mem_addr, 16'h0000);
        chk({nm, ".rd_en"}, mem_rd_en, 1'b0);
        chk({nm, ".valid"}, out_valid, 1'b0);
        chk({nm, ".busy"}, busy, 1'b0);
        chk({nm, ".done"}, done, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        in_w = 8'd0; in_h = 8'd0; out_w = 8'd0; out_h = 8'd0;
        step_x = 16'd0; step_y = 16'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) mem[r * 4 + c] = pix(c, r);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        cmp_en = 1'b1;
        done_chk_en = 1'b1;

        // Integer step, first-valid latency and a start pulse while busy
        build_model(4, 4, 2, 2, 16'h0200, 16'h0200);
        chk_samp("pin_int0", q[0], 16'h0000, 16'h0000, 0, 1, 16, 17);
        chk_samp("pin_int1", q[1], 16'h0200, 16'h0000, 2, 3, 18, 19);
        chk_samp("pin_int2", q[2], 16'h0000, 16'h0200, 32, 33, 48, 49);
        chk_samp("pin_int3", q[3], 16'h0200, 16'h0200, 34, 35, 50, 51);
        start_frame(2, 2, 16'h0200, 16'h0200);
        repeat (4) @(posedge clk);
        #1;
        chk("latency_before", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("latency_first", out_valid, 1'b1);
        out_w = 8'd3; out_h = 8'd3; step_x = 16'h0100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_frame(4);

        // Fractional step
        build_model(4, 4, 3, 3, 16'h0155, 16'h0155);
        chk_samp("pin_frac1", q[1], 16'h0155, 16'h0000, 1, 2, 17, 18);
        chk_samp("pin_frac2", q[2], 16'h02AA, 16'h0000, 2, 3, 18, 19);
        chk_samp("pin_frac3", q[3], 16'h0000, 16'h0155, 16, 17, 32, 33);
        start_frame(3, 3, 16'h0155, 16'h0155);
        wait_frame(9);

        // Right/bottom edge neighbours
        build_model(4, 4, 3, 3, 16'h0180, 16'h0180);
        chk_samp("pin_edge2", q[2], 16'h0300, 16'h0000, 3, 3, 19, 19);
        chk_samp("pin_edge8", q[8], 16'h0300, 16'h0300, 51, 51, 51, 51);
        start_frame(3, 3, 16'h0180, 16'h0180);
        wait_frame(9);

        // Coordinates beyond the map clamp with zero fraction
        build_model(4, 4, 2, 2, 16'h0480, 16'h0480);
        chk_samp("pin_clamp1", q[1], 16'h0300, 16'h0000, 3, 3, 19, 19);
        chk_samp("pin_clamp2", q[2], 16'h0000, 16'h0300, 48, 49, 48, 49);
        start_frame(2, 2, 16'h0480, 16'h0480);
        wait_frame(4);

        // Backpressure on the second sample
        build_model(4, 4, 2, 2, 16'h0200, 16'h0200);
        start_frame(2, 2, 16'h0200, 16'h0200);
        wait_acc(1);
        out_ready = 1'b0;
        begin
            int k = 0;
            while (out_valid !== 1'b1 && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            chk("bp_valid_timeout", (k < 50), 1'b1);
        end
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_valid_held", out_valid, 1'b1);
            chk("bp_no_read", mem_rd_en, 1'b0);
            chk("bp_no_accept", n_acc, 1);
        end
        out_ready = 1'b1;
        wait_frame(4);

        // Degenerate config: done one cycle later, no samples
        done_chk_en = 1'b0;
        q.delete();
        n_acc = 0;
        @(posedge clk); #1;
        in_w = 8'd4; in_h = 8'd4; out_w = 8'd0; out_h = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("degen_done", done, 1'b1);
        chk("degen_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("degen_done_once", done, 1'b0);
        repeat (8) begin
            @(posedge clk); #1;
            chk("degen_no_valid", out_valid, 1'b0);
        end
        chk("degen_busy", busy, 1'b0);
        done_chk_en = 1'b1;

        // Reset during the fetch of the third sample, then a clean frame
        build_model(4, 4, 2, 2, 16'h0200, 16'h0200);
        start_frame(2, 2, 16'h0200, 16'h0200);
        wait_acc(2);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        chk_zero("midreset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        build_model(4, 4, 2, 2, 16'h0200, 16'h0200);
        start_frame(2, 2, 16'h0200, 16'h0200);
        wait_frame(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
